channel_loader: RTL and testbench

- Front-end feeder for the SCAN decoder storage block.
- Accepts a beat stream of wide channel LLRs, saturates each LLR to Q bits and packs P of them into one storage word.
- Drives the storage channel-initialisation port: W_channel, channel_count, channel_ready and channel=0 during load.
- After a full frame of N LLRs it hands control to the decoder: channel=1 plus a dec_start pulse. It waits for dec_done before loading the next frame.

---
 rtl/channel_loader.sv | 147 ++++++++++++++
 tb/tb_channel_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_loader.sv
// Channel LLR loader: saturates an input beat stream to Q-bit LLRs, packs P of
// them per storage word, then hands the storage to the decoder for one frame.
module channel_loader #(
  parameter int N  = 1024,
  parameter int P  = 128,
  parameter int Q  = 6,
  parameter int IW = 8,
  parameter int K  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [K*IW-1:0] s_data,
  input  logic            s_valid,
  input  logic            s_last,
  output logic            s_ready,
  output logic [P*Q-1:0]  W_channel,
  output logic [5:0]      channel_count,
  output logic            channel_ready,
  output logic            channel,
  output logic            dec_start,
  input  logic            dec_done,
  output logic            frame_err,
  output logic [15:0]     frame_cnt
);

  localparam int BPW     = P / K;
  localparam int WORDS   = N / P;
  localparam int BW      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int SAT_MAX = (1 << (Q - 1)) - 1;

  localparam logic signed [IW-1:0] SAT_HI = IW'(SAT_MAX);
  localparam logic signed [IW-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [BW-1:0]  beat_reg;
  logic [5:0]     word_reg;
  logic [K*Q-1:0] pack_reg   [BPW];
  logic [K*Q-1:0] group_next [BPW];
  logic [K*Q-1:0] sat_beat;
  logic [P*Q-1:0] word_next;

  logic transfer;
  logic word_end;
  logic frame_end;
  logic s_ready_next;
  logic channel_next;
  logic dec_start_next;

  assign transfer  = s_valid && s_ready && (state_reg == LOAD);
  assign word_end  = transfer && (beat_reg == BW'(BPW - 1));
  assign frame_end = word_end && (word_reg == 6'(WORDS - 1));

  // Symmetric clamp: the most negative Q-bit code is never produced.
  for (genvar gi = 0; gi < K; gi++) begin : g_sat
    logic signed [IW-1:0] x;
    assign x = s_data[gi*IW +: IW];
    assign sat_beat[gi*Q +: Q] = (x > SAT_HI) ? SAT_HI[Q-1:0] :
                                 (x < SAT_LO) ? SAT_LO[Q-1:0] :
                                                x[Q-1:0];
  end

  // The word image includes the beat being accepted, so the final beat of a
  // word is visible in W_channel without an extra pipeline stage.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_pack
    assign group_next[gi] = (transfer && (beat_reg == BW'(gi))) ? sat_beat : pack_reg[gi];
    assign word_next[gi*K*Q +: K*Q] = group_next[gi];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pack_reg[gi] <= '0;
      end else begin
        pack_reg[gi] <= group_next[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_reg <= '0;
      word_reg <= '0;
    end else if (transfer) begin
      beat_reg <= word_end ? '0 : beat_reg + 1'b1;
      if (word_end) begin
        word_reg <= frame_end ? 6'd0 : word_reg + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (frame_end) state_next = START;
      START:   state_next = DECODE;
      DECODE:  if (dec_done) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Outputs are decoded from the upcoming state and then registered.
  always_comb begin
    s_ready_next   = (state_next == LOAD);
    channel_next   = (state_next == DECODE);
    dec_start_next = (state_reg == START);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready       <= 1'b0;
      channel       <= 1'b0;
      dec_start     <= 1'b0;
      channel_ready <= 1'b0;
      frame_err     <= 1'b0;
      frame_cnt     <= '0;
      W_channel     <= '0;
      channel_count <= '0;
    end else begin
      s_ready       <= s_ready_next;
      channel       <= channel_next;
      dec_start     <= dec_start_next;
      channel_ready <= word_end;
      frame_err     <= transfer && (s_last != frame_end);
      if (word_end) begin
        W_channel     <= word_next;
        channel_count <= word_reg;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_channel_loader.sv
// Self-checking bench for channel_loader: scoreboarded word strobes, a table of
// saturation vectors, and hand-written handover / error / reset sequences.
module tb_channel_loader;

  localparam int N     = 1024;
  localparam int P     = 128;
  localparam int Q     = 6;
  localparam int IW    = 8;
  localparam int K     = 4;
  localparam int BPW   = P / K;
  localparam int WORDS = N / P;
  localparam int BEATS = N / K;
  localparam int NT    = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [K*IW-1:0] s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            s_ready;
  logic [P*Q-1:0]  W_channel;
  logic [5:0]      channel_count;
  logic            channel_ready;
  logic            channel;
  logic            dec_start;
  logic            dec_done = 1'b0;
  logic            frame_err;
  logic [15:0]     frame_cnt;

  always #5 clk = ~clk;

  channel_loader #(.N(N), .P(P), .Q(Q), .IW(IW), .K(K)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .W_channel    (W_channel),
    .channel_count(channel_count),
    .channel_ready(channel_ready),
    .channel      (channel),
    .dec_start    (dec_start),
    .dec_done     (dec_done),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt)
  );

  typedef struct {
    logic [P*Q-1:0] word;
    logic [5:0]     idx;
  } exp_word_t;

  typedef struct {
    logic signed [IW-1:0] in_llr;
    logic signed [Q-1:0]  exp_llr;
  } vec_t;

  exp_word_t sb[$];
  exp_word_t e;
  vec_t      tbl[NT];
  int        tin[NT] = '{127, -128, 31, -32, 0, -1, 32, -31, 30, 100, -100, 5};
  int        tex[NT] = '{31, -31, 31, -31, 0, -1, 31, -31, 30, 31, -31, 5};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;
  bit spacing_on = 1'b0;
  int last_strobe = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int llr_val(input int i);
    int v;
    case (mode)
      0:       v = (i % 61) - 30;
      1:       v = tbl[i % NT].in_llr;
      default: v = ((i * 37) % 256) - 128;
    endcase
    return v;
  endfunction

  function automatic int sat_model(input int x);
    if (x > 31) return 31;
    if (x < -31) return -31;
    return x;
  endfunction

  function automatic logic [P*Q-1:0] exp_word(input int w);
    logic [P*Q-1:0] r;
    for (int j = 0; j < P; j++) r[j*Q +: Q] = Q'(sat_model(llr_val(w * P + j)));
    return r;
  endfunction

  // Scoreboard: every storage strobe must match the next expected word.
  always @(negedge clk) begin
    if (rst === 1'b1 && channel_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got channel_count=%0d with no word expected", channel_count);
      end else begin
        e = sb.pop_front();
        total++;
        if (W_channel !== e.word) begin
          bad++;
          $display("FAIL word%0d_data: got lanes0-3 %h expected %h", e.idx, W_channel[4*Q-1:0], e.word[4*Q-1:0]);
        end
        chk("channel_count", 64'(channel_count), 64'(e.idx));
        if (spacing_on && e.idx != 0 && last_strobe >= 0)
          chk("strobe_spacing", 64'(cyc - last_strobe), 64'(BPW));
        last_strobe = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [K*IW-1:0] d, input logic last);
    bit acc = 1'b0;
    bit acc_now;
    int guard = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    while (!acc) begin
      acc_now = s_ready;
      step();
      if (acc_now) acc = 1'b1;
      else if (++guard > 1000) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got no s_ready in %0d cycles expected acceptance", guard);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input bit throttle, input int bad_beat);
    logic [K*IW-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < K; k++) d[k*IW +: IW] = IW'(llr_val(b * K + k));
      if (throttle) begin
        while ($urandom_range(1, 0) == 1) begin
          dec_done = 1'($urandom_range(1, 0));
          step();
        end
        dec_done = 1'($urandom_range(1, 0));
      end
      if (b % BPW == BPW - 1) sb.push_back('{exp_word(b / BPW), 6'(b / BPW)});
      send_beat(d, (b == BEATS - 1) || (b == bad_beat));
      dec_done = 1'b0;
      chk("frame_err", 64'(frame_err), 64'((b == bad_beat && b != BEATS - 1) ? 1 : 0));
      chk("strobe_after_beat", 64'(channel_ready), 64'((b % BPW == BPW - 1) ? 1 : 0));
    end
  endtask

  // Called at t+1 after the final beat; owns the decode phase and handover.
  task automatic end_of_frame(input int exp_frames, input int hold);
    int viol = 0;
    chk("t1_channel", 64'(channel), 64'(0));
    chk("t1_s_ready", 64'(s_ready), 64'(0));
    chk("t1_channel_count", 64'(channel_count), 64'(WORDS - 1));
    chk("t1_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    step();
    chk("t2_channel", 64'(channel), 64'(1));
    chk("t2_dec_start", 64'(dec_start), 64'(1));
    s_valid = 1'b1;
    s_last  = 1'b1;
    for (int c = 0; c < hold; c++) begin
      s_data = $urandom;
      step();
      if (s_ready !== 1'b0 || channel !== 1'b1 || dec_start !== 1'b0 || frame_err !== 1'b0) viol++;
    end
    chk("decode_hold_violations", 64'(viol), 64'(0));
    chk("decode_hold_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    s_valid  = 1'b0;
    s_last   = 1'b0;
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    chk("handover_channel", 64'(channel), 64'(0));
    chk("handover_s_ready", 64'(s_ready), 64'(1));
  endtask

  initial begin
    for (int i = 0; i < NT; i++) tbl[i] = '{IW'(tin[i]), Q'(tex[i])};

    // Reset and idle
    for (int c = 0; c < 3; c++) begin
      step();
      chk("reset_outputs", {channel_count, frame_cnt, s_ready, channel, channel_ready, dec_start, frame_err}, 64'(0));
      chk("reset_W_channel_zero", 64'(W_channel == '0), 64'(1));
    end
    rst = 1'b1;
    chk("s_ready_before_edge", 64'(s_ready), 64'(0));
    step();
    chk("s_ready_after_release", 64'(s_ready), 64'(1));

    // Full frame, back-to-back, long decode hold
    mode = 0; spacing_on = 1'b1;
    send_frame(BEATS, 1'b0, -1);
    end_of_frame(1, 500);

    // Saturation table frame
    mode = 1;
    send_frame(BEATS, 1'b0, -1);
    end_of_frame(2, 3);
    for (int j = 0; j < NT; j++) begin
      logic [Q-1:0] ev;
      ev = tbl[((WORDS - 1) * P + j) % NT].exp_llr;
      chk($sformatf("sat_lane%0d_in%0d", j, tbl[((WORDS - 1) * P + j) % NT].in_llr), 64'(W_channel[j*Q +: Q]), 64'(ev));
    end

    // Throttled input with dec_done noise during load
    mode = 0; spacing_on = 1'b0;
    send_frame(BEATS, 1'b1, -1);
    end_of_frame(3, 10);

    // Early s_last on beat 100
    spacing_on = 1'b1;
    send_frame(BEATS, 1'b0, 100);
    end_of_frame(4, 2);

    // Reset mid-frame, then a fresh frame
    mode = 2;
    send_frame(150, 1'b0, -1);
    rst = 1'b0;
    #1;
    chk("midrst_s_ready", 64'(s_ready), 64'(0));
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("midrst_channel_count", 64'(channel_count), 64'(0));
    chk("midrst_W_channel_zero", 64'(W_channel == '0), 64'(1));
    sb.delete();
    last_strobe = -1;
    step();
    step();
    rst = 1'b1;
    step();
    chk("postrst_s_ready", 64'(s_ready), 64'(1));
    chk("postrst_frame_cnt", 64'(frame_cnt), 64'(0));
    send_frame(BEATS, 1'b0, -1);
    end_of_frame(1, 5);

    step();
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got no completion by time %0t expected finish", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
